back_ground_scroller: RTL and testbench

//  Parametrised, animated background generator for the VGA path; next generation of the static background drawer.

---
 rtl/bg_pkg.sv | 23 ++
 rtl/bg_flash_ctrl.sv | 125 ++++++++++++
 rtl/back_ground_scroller.sv | 130 +++++++++++++
 tb/tb_back_ground_scroller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// -----------------------------------------------------------------------------
// bg_pkg
// Shared types and default colours for the animated background generator.
//   flash_state_t : border flash controller states
//   DEF_*         : default colour palette (RRRGGGBB)
// -----------------------------------------------------------------------------
package bg_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } flash_state_t;

    localparam logic [7:0] DEF_COLOR_A       = 8'h58;
    localparam logic [7:0] DEF_COLOR_B       = 8'h4C;
    localparam logic [7:0] DEF_BORDER_COLOR  = 8'hFC;
    localparam logic [7:0] DEF_BRACKET_COLOR = 8'hFF;
    localparam logic [7:0] DEF_FLASH_COLOR   = 8'hE0;
    localparam logic [7:0] BLANK_COLOR       = 8'h00;
    localparam logic [7:0] RESET_COLOR       = 8'hFF;

endpackage

// File: rtl/bg_flash_ctrl.sv
// -----------------------------------------------------------------------------
// bg_flash_ctrl
// Border flash sequencer. A request makes the border alternate between the
// flash colour (ON half) and the normal border colour (OFF half) for
// FLASH_COUNT ON/OFF pairs, each half lasting FLASH_FRAMES frames. All state
// moves only on start-of-frame so a frame is never drawn half-flashed.
// Ports:
//   clk, resetN      : pixel clock, async active-low reset
//   i_sof            : one-clk start-of-frame pulse
//   i_flash_req      : one-clk flash request (restarts a running flash)
//   o_flash_on       : border must use the flash colour
//   o_flash_active   : registered, high while not IDLE
// -----------------------------------------------------------------------------
module bg_flash_ctrl
    import bg_pkg::*;
#(
    parameter int unsigned FLASH_FRAMES = 8,
    parameter int unsigned FLASH_COUNT  = 3
) (
    input  logic clk,
    input  logic resetN,
    input  logic i_sof,
    input  logic i_flash_req,
    output logic o_flash_on,
    output logic o_flash_active
);

    localparam int FRM_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int BLK_W = $clog2(FLASH_COUNT + 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FLASH_FRAMES - 1);
    localparam logic [BLK_W-1:0] BLK_MAX  = BLK_W'(FLASH_COUNT);

    flash_state_t     r_state;
    flash_state_t     w_state_nxt;
    logic [FRM_W-1:0] r_frm_cnt;
    logic [FRM_W-1:0] w_frm_nxt;
    logic [BLK_W-1:0] r_blink_cnt;
    logic [BLK_W-1:0] w_blink_nxt;
    logic             r_pending;
    logic             w_pending_nxt;
    logic             r_flash_active;

    // State register: FSM state, counters, pending latch and active flag
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state        <= IDLE;
            r_frm_cnt      <= {FRM_W{1'b0}};
            r_blink_cnt    <= {BLK_W{1'b0}};
            r_pending      <= 1'b0;
            r_flash_active <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_frm_cnt      <= w_frm_nxt;
            r_blink_cnt    <= w_blink_nxt;
            r_pending      <= w_pending_nxt;
            // Driven from the next state so the flag lines up with r_state.
            r_flash_active <= (w_state_nxt != IDLE);
        end
    end

    // Next-state logic: a request (latched or same-cycle) always restarts at ON
    always_comb begin
        w_state_nxt   = r_state;
        w_frm_nxt     = r_frm_cnt;
        w_blink_nxt   = r_blink_cnt;
        w_pending_nxt = r_pending;
        if (i_sof) begin
            w_pending_nxt = 1'b0;
            if (r_pending || i_flash_req) begin
                w_state_nxt = FLASH_ON;
                w_frm_nxt   = {FRM_W{1'b0}};
                w_blink_nxt = {BLK_W{1'b0}};
            end else begin
                case (r_state)
                    IDLE: begin
                        w_state_nxt = IDLE;
                    end
                    FLASH_ON: begin
                        if (r_frm_cnt == FRM_LAST) begin
                            w_state_nxt = FLASH_OFF;
                            w_frm_nxt   = {FRM_W{1'b0}};
                            w_blink_nxt = r_blink_cnt + BLK_W'(1);
                        end else begin
                            w_frm_nxt = r_frm_cnt + FRM_W'(1);
                        end
                    end
                    FLASH_OFF: begin
                        if (r_frm_cnt == FRM_LAST) begin
                            w_frm_nxt = {FRM_W{1'b0}};
                            if (r_blink_cnt < BLK_MAX) begin
                                w_state_nxt = FLASH_ON;
                            end else begin
                                w_state_nxt = IDLE;
                            end
                        end else begin
                            w_frm_nxt = r_frm_cnt + FRM_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE;
                        w_frm_nxt   = {FRM_W{1'b0}};
                        w_blink_nxt = {BLK_W{1'b0}};
                    end
                endcase
            end
        end else if (i_flash_req) begin
            w_pending_nxt = 1'b1;
        end else begin
            w_pending_nxt = r_pending;
        end
    end

    // Output decode: flash colour only during ON halves
    always_comb begin
        o_flash_on = 1'b0;
        if (r_state == FLASH_ON) begin
            o_flash_on = 1'b1;
        end else begin
            o_flash_on = 1'b0;
        end
    end

    assign o_flash_active = r_flash_active;

endmodule

// File: rtl/back_ground_scroller.sv
// -----------------------------------------------------------------------------
// back_ground_scroller
// Animated VGA background: outer border, inner bracket and a two-colour
// checkerboard that scrolls horizontally on frame boundaries. The border can
// be made to blink through bg_flash_ctrl. BG_RGB feeds the lowest-priority
// input of the object mux.
// Ports:
//   clk, resetN          : pixel clock, async active-low reset
//   pixelX, pixelY       : current pixel coordinate (11 bit)
//   startOfFrame         : one-clk pulse per frame
//   scrollEn, scrollDir  : scroll enable; 0 = offset increments, 1 = decrements
//   flashReq             : one-clk border flash request
//   BG_RGB               : registered RRRGGGBB colour, one clk behind pixelX/Y
//   flashActive          : registered, high while a flash sequence runs
// -----------------------------------------------------------------------------
module back_ground_scroller
    import bg_pkg::*;
#(
    parameter int unsigned X_FRAME        = 639,
    parameter int unsigned Y_FRAME        = 479,
    parameter int unsigned BRACKET_OFFSET = 10,
    parameter int unsigned TILE_LOG2      = 5,
    parameter int unsigned SCROLL_STEP    = 1,
    parameter int unsigned SCROLL_DIV     = 2,
    parameter int unsigned FLASH_FRAMES   = 8,
    parameter int unsigned FLASH_COUNT    = 3,
    parameter logic [7:0]  COLOR_A        = DEF_COLOR_A,
    parameter logic [7:0]  COLOR_B        = DEF_COLOR_B,
    parameter logic [7:0]  BORDER_COLOR   = DEF_BORDER_COLOR,
    parameter logic [7:0]  BRACKET_COLOR  = DEF_BRACKET_COLOR,
    parameter logic [7:0]  FLASH_COLOR    = DEF_FLASH_COLOR
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        scrollEn,
    input  logic        scrollDir,
    input  logic        flashReq,
    output logic [7:0]  BG_RGB,
    output logic        flashActive
);

    // Offset is one bit wider than the tile edge: it spans exactly two tiles,
    // i.e. one full checker period, so natural wrap keeps the pattern seamless.
    localparam int SCR_W = TILE_LOG2 + 1;
    localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [SCR_W-1:0] STEP_V    = SCR_W'(SCROLL_STEP);
    localparam logic [SCR_W-1:0] HALF_WRAP = SCR_W'(1 << TILE_LOG2);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCROLL_DIV - 1);
    localparam logic [10:0] X_F    = 11'(X_FRAME);
    localparam logic [10:0] Y_F    = 11'(Y_FRAME);
    localparam logic [10:0] BR_LT  = 11'(BRACKET_OFFSET);
    localparam logic [10:0] BR_R   = 11'(X_FRAME - BRACKET_OFFSET);
    localparam logic [10:0] BR_B   = 11'(Y_FRAME - BRACKET_OFFSET);

    logic [SCR_W-1:0] r_scroll_x;
    logic [DIV_W-1:0] r_div_cnt;
    logic [SCR_W-1:0] w_sum_x;
    logic             w_sel;
    logic             w_flash_on;
    logic [7:0]       w_rgb_nxt;
    logic [7:0]       r_bg_rgb;

    bg_flash_ctrl #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .FLASH_COUNT  (FLASH_COUNT)
    ) u_flash (
        .clk            (clk),
        .resetN         (resetN),
        .i_sof          (startOfFrame),
        .i_flash_req    (flashReq),
        .o_flash_on     (w_flash_on),
        .o_flash_active (flashActive)
    );

    // Scroll divider and offset: offset moves only on start-of-frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_scroll_x <= {SCR_W{1'b0}};
            r_div_cnt  <= {DIV_W{1'b0}};
        end else if (!scrollEn) begin
            r_div_cnt <= {DIV_W{1'b0}};
        end else if (startOfFrame) begin
            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt  <= {DIV_W{1'b0}};
                r_scroll_x <= scrollDir ? (r_scroll_x - STEP_V) : (r_scroll_x + STEP_V);
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    // Only the low bits of pixelX influence the tile-select bit of the
    // shifted column, so a narrow add suffices; the select bit is the MSB
    // of that sum, tested as "sum >= half the wrap".
    assign w_sum_x = pixelX[TILE_LOG2:0] + r_scroll_x;
    assign w_sel   = (w_sum_x >= HALF_WRAP) ^ pixelY[TILE_LOG2];

    // Pixel classification in priority order: blank, border, bracket, checker
    always_comb begin
        w_rgb_nxt = COLOR_A;
        if ((pixelX > X_F) || (pixelY > Y_F)) begin
            w_rgb_nxt = BLANK_COLOR;
        end else if ((pixelX == 11'd0) || (pixelY == 11'd0) ||
                     (pixelX == X_F)   || (pixelY == Y_F)) begin
            w_rgb_nxt = w_flash_on ? FLASH_COLOR : BORDER_COLOR;
        end else if ((pixelX == BR_LT) || (pixelY == BR_LT) ||
                     (pixelX == BR_R)  || (pixelY == BR_B)) begin
            w_rgb_nxt = BRACKET_COLOR;
        end else if (w_sel) begin
            w_rgb_nxt = COLOR_B;
        end else begin
            w_rgb_nxt = COLOR_A;
        end
    end

    // Output register: one clock of latency from pixel coordinate to colour
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_bg_rgb <= RESET_COLOR;
        end else begin
            r_bg_rgb <= w_rgb_nxt;
        end
    end

    assign BG_RGB = r_bg_rgb;

endmodule

// File: tb/tb_back_ground_scroller.sv
// -----------------------------------------------------------------------------
// tb_back_ground_scroller
// Directed + randomized bench for back_ground_scroller. A frame-level model
// (scroll offset as an integer modulo the checker period, flash as a frame
// count since the last request) predicts BG_RGB / flashActive every clock.
// -----------------------------------------------------------------------------
module tb_back_ground_scroller;

    localparam int WRAP       = 64;   // two 32-px tiles
    localparam int FLASH_LEN  = 48;   // 3 pairs x (8 ON + 8 OFF) frames

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [10:0] pixelX = 11'd0;
    logic [10:0] pixelY = 11'd0;
    logic        startOfFrame = 1'b0;
    logic        scrollEn = 1'b0;
    logic        scrollDir = 1'b0;
    logic        flashReq = 1'b0;
    logic [7:0]  BG_RGB;
    logic        flashActive;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // model state
    int       m_scroll = 0;
    int       m_div = 0;
    int       m_ff = 0;
    bit       m_act = 1'b0;
    bit       m_pend = 1'b0;
    logic [7:0] exp_rgb = 8'hFF;
    logic       exp_act = 1'b0;

    int kx[6] = '{0, 10, 629, 639, 640, 700};
    int ky[5] = '{0, 10, 469, 479, 480};

    back_ground_scroller dut (
        .clk          (clk),
        .resetN       (resetN),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .startOfFrame (startOfFrame),
        .scrollEn     (scrollEn),
        .scrollDir    (scrollDir),
        .flashReq     (flashReq),
        .BG_RGB       (BG_RGB),
        .flashActive  (flashActive)
    );

    always #5 clk = ~clk;

    // Colour straight from the drawing rules
    function automatic logic [7:0] ref_color(input int x, input int y, input int s, input bit fon);
        if (x > 639 || y > 479) return 8'h00;
        if (x == 0 || y == 0 || x == 639 || y == 479) return fon ? 8'hE0 : 8'hFC;
        if (x == 10 || y == 10 || x == 629 || y == 469) return 8'hFF;
        // xor of the tile-index LSBs == parity of their sum
        return ((((x + s) / 32) + (y / 32)) % 2 == 1) ? 8'h4C : 8'h58;
    endfunction

    // Behavioural model
    always @(posedge clk or negedge resetN) begin
        int s, d, f;
        bit a, p;
        if (!resetN) begin
            m_scroll <= 0; m_div <= 0; m_ff <= 0; m_act <= 1'b0; m_pend <= 1'b0;
            exp_rgb <= 8'hFF; exp_act <= 1'b0;
        end else begin
            s = m_scroll; d = m_div; f = m_ff; a = m_act; p = m_pend;
            exp_rgb <= ref_color(int'(pixelX), int'(pixelY), m_scroll, m_act && ((m_ff / 8) % 2 == 0));
            if (!scrollEn) d = 0;
            else if (startOfFrame) begin
                d = d + 1;
                if (d == 2) begin
                    d = 0;
                    s = scrollDir ? (s + WRAP - 1) % WRAP : (s + 1) % WRAP;
                end
            end
            if (startOfFrame) begin
                if (p || flashReq) begin a = 1'b1; f = 0; end
                else if (a) begin
                    f = f + 1;
                    if (f == FLASH_LEN) a = 1'b0;
                end
                p = 1'b0;
            end else if (flashReq) p = 1'b1;
            m_scroll <= s; m_div <= d; m_ff <= f; m_act <= a; m_pend <= p;
            exp_act <= a;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (BG_RGB !== exp_rgb) begin
                n_bad++;
                $display("FAIL model_rgb t=%0t: BG_RGB=%h expected %h", $time, BG_RGB, exp_rgb);
            end
            n_cmp++;
            if (flashActive !== exp_act) begin
                n_bad++;
                $display("FAIL model_active t=%0t: flashActive=%b expected %b", $time, flashActive, exp_act);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rand_px();
        pixelX = ($urandom_range(0, 7) == 0) ? 11'(kx[$urandom_range(0, 5)]) : 11'($urandom_range(0, 719));
        pixelY = ($urandom_range(0, 7) == 0) ? 11'(ky[$urandom_range(0, 4)]) : 11'($urandom_range(0, 519));
    endtask

    task automatic step(input bit sof, input bit req);
        @(negedge clk);
        startOfFrame = sof;
        flashReq = req;
        rand_px();
    endtask

    task automatic sof_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0);
            repeat ($urandom_range(1, 4)) step(1'b0, 1'b0);
        end
    endtask

    // Drive one pixel, check the registered colour one clock later
    task automatic lit(input int x, input int y, input logic [7:0] exp, input string nm);
        @(negedge clk);
        pixelX = 11'(x); pixelY = 11'(y);
        startOfFrame = 1'b0; flashReq = 1'b0;
        @(posedge clk);
        #1;
        chk(nm, 32'(BG_RGB), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset state and static classification
        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("reset_rgb", 32'(BG_RGB), 32'hFF);
        chk("reset_active", 32'(flashActive), 32'h0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        lit(5, 0, 8'hFC, "border_top");
        lit(10, 100, 8'hFF, "bracket_left");
        lit(40, 40, 8'h58, "checker_a");
        lit(700, 100, 8'h00, "offscreen");
        lit(629, 300, 8'hFF, "bracket_right");
        lit(639, 479, 8'hFC, "border_corner");

        // 2. scroll left: two SOFs per step, 128 SOFs return to zero
        scrollEn = 1'b1; scrollDir = 1'b0;
        sof_n(2);
        lit(63, 40, 8'h4C, "scroll1_63_40");
        sof_n(126);
        chk("model_scroll_wrap", 32'(m_scroll), 32'd0);
        lit(32, 40, 8'h58, "scroll0_32_40");

        // 3. scroll right from zero wraps to 63
        scrollDir = 1'b1;
        sof_n(2);
        lit(40, 40, 8'h58, "scroll63_40_40");
        lit(32, 40, 8'h4C, "scroll63_32_40");
        scrollEn = 1'b0;
        sof_n(5);
        lit(32, 40, 8'h4C, "scroll_hold");

        // 4. flash request then SOF
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        sof_n(1);
        lit(5, 0, 8'hE0, "flash_on");
        chk("flash_active_on", 32'(flashActive), 32'h1);
        sof_n(7);
        lit(5, 0, 8'hE0, "flash_on_last");
        sof_n(1);
        lit(5, 0, 8'hFC, "flash_off");
        sof_n(39);
        chk("flash_active_47", 32'(flashActive), 32'h1);
        sof_n(1);
        #1;
        chk("flash_idle_48", 32'(flashActive), 32'h0);

        // 5. request coincident with SOF, then restart during OFF
        step(1'b1, 1'b1);
        lit(5, 0, 8'hE0, "flash_coincident");
        chk("flash_coinc_active", 32'(flashActive), 32'h1);
        sof_n(8);
        lit(5, 0, 8'hFC, "flash_off_before_restart");
        step(1'b0, 1'b1);
        sof_n(1);
        lit(5, 0, 8'hE0, "flash_restart");
        sof_n(47);
        chk("restart_active_47", 32'(flashActive), 32'h1);
        sof_n(1);
        #1;
        chk("restart_idle_48", 32'(flashActive), 32'h0);

        // 6. async reset mid-flash and mid-scroll
        scrollEn = 1'b1; scrollDir = 1'b0;
        sof_n(5);
        step(1'b1, 1'b1);
        sof_n(3);
        @(posedge clk); #2;
        resetN = 1'b0;
        #1;
        chk("async_reset_rgb", 32'(BG_RGB), 32'hFF);
        chk("async_reset_active", 32'(flashActive), 32'h0);
        scrollEn = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        lit(32, 40, 8'h58, "post_reset_scroll0");
        lit(5, 0, 8'hFC, "post_reset_no_flash");

        // 7. randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) scrollEn = ~scrollEn;
            if ($urandom_range(0, 79) == 0) scrollDir = ~scrollDir;
            step(($urandom_range(0, 5) == 0), ($urandom_range(0, 49) == 0));
        end
        step(1'b0, 1'b0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
